program_counter: RTL and testbench



---
 rtl/program_counter_pkg.sv | 31 +++
 rtl/program_counter.sv | 51 +++++
 tb/tb_program_counter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/program_counter_pkg.sv
// Shared CPU definitions used by the program counter.
//   ADDR_WIDTH : width of instruction addresses on the memory-address path
//   addr_t     : address type of ADDR_WIDTH bits
//   pc_op_e    : per-edge PC action decoded from the Cp/Ep control lines
//   pc_decode  : maps the Cp/Ep control lines to a pc_op_e
package program_counter_pkg;

  localparam int unsigned ADDR_WIDTH = 4;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [1:0] {
    PcHold,
    PcInc,
    PcLoad
  } pc_op_e;

  // Cp gates everything; Ep only selects between increment and load.
  function automatic pc_op_e pc_decode(input logic cp, input logic ep);
    pc_op_e op;
    if (!cp) begin
      op = PcHold;
    end else if (ep) begin
      op = PcInc;
    end else begin
      op = PcLoad;
    end
    return op;
  endfunction

endpackage

// File: rtl/program_counter.sv
// Program counter of the 4-bit CPU. Holds the address of the next instruction.
// Ports:
//   clk   : system clock, rising-edge active
//   rst   : synchronous, active-high reset; loads RESET_VAL
//   Cp    : counter enable (0 = hold, 1 = update this edge)
//   Ep    : mode when Cp=1 (1 = increment, 0 = load Ci)
//   Ci    : parallel load value (jump target)
//   count : current PC value, straight from the register
module program_counter
  import program_counter_pkg::*;
#(
  parameter int unsigned          WIDTH     = ADDR_WIDTH,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Cp,
  input  logic             Ep,
  input  logic [WIDTH-1:0] Ci,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  pc_op_e           op;

  assign op = pc_decode(Cp, Ep);

  // Ci is only selected on a load, so an undriven Ci cannot leak into count
  // while holding or incrementing.
  always_comb begin
    count_d = count_q;
    unique case (op)
      PcHold:  count_d = count_q;
      PcInc:   count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
      PcLoad:  count_d = Ci;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RESET_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  localparam int unsigned W = 4;
  localparam int unsigned MODV = 1 << W;

  logic         clk;
  logic         rst;
  logic         Cp;
  logic         Ep;
  logic [W-1:0] Ci;
  logic [W-1:0] count;

  int n_cmp;
  int n_err;
  int exp_pc;

  program_counter #(
    .WIDTH    (W),
    .RESET_VAL(4'b0000)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .Cp   (Cp),
    .Ep   (Ep),
    .Ci   (Ci),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; Cp = 1'b1; Ep = 1'b1; Ci = 4'b1010;
    tick();
    n_cmp++;
    if (count !== 4'b0000) begin
      n_err++;
      $display("FAIL reset: count=%b expected=0000", count);
    end
    rst = 1'b0;
  endtask

  task automatic test_hold();
    rst = 1'b0; Cp = 1'b0; Ep = 1'b1; Ci = 4'b0111;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (count !== 4'b0000) begin
        n_err++;
        $display("FAIL hold[%0d]: count=%b expected=0000", i, count);
      end
    end
  endtask

  task automatic test_count();
    logic [W-1:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101};
    Cp = 1'b1; Ep = 1'b1; Ci = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (count !== exp_seq[i]) begin
        n_err++;
        $display("FAIL count[%0d]: count=%b expected=%b", i, count, exp_seq[i]);
      end
    end
  endtask

  task automatic test_load();
    logic [W-1:0] exp_seq [3];
    exp_seq = '{4'b0010, 4'b0011, 4'b0100};
    Cp = 1'b1; Ep = 1'b0; Ci = 4'b0001;
    tick();
    n_cmp++;
    if (count !== 4'b0001) begin
      n_err++;
      $display("FAIL load: count=%b expected=0001", count);
    end
    Ep = 1'b1; Ci = 'x;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (count !== exp_seq[i]) begin
        n_err++;
        $display("FAIL load_then_inc[%0d]: count=%b expected=%b", i, count, exp_seq[i]);
      end
    end
    // Repeated load reloads Ci every edge.
    Ep = 1'b0;
    for (int i = 0; i < 2; i++) begin
      Ci = (i == 0) ? 4'b1100 : 4'b0011;
      tick();
      n_cmp++;
      if (count !== Ci) begin
        n_err++;
        $display("FAIL reload[%0d]: count=%b expected=%b", i, count, Ci);
      end
    end
    // Hold with Ci undriven must keep the value clean.
    Cp = 1'b0; Ep = 1'b0; Ci = 'x;
    tick();
    n_cmp++;
    if (count !== 4'b0011) begin
      n_err++;
      $display("FAIL hold_ci_x: count=%b expected=0011", count);
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp_seq [3];
    exp_seq = '{4'b1111, 4'b0000, 4'b0001};
    Cp = 1'b1; Ep = 1'b0; Ci = 4'b1110;
    tick();
    n_cmp++;
    if (count !== 4'b1110) begin
      n_err++;
      $display("FAIL wrap_load: count=%b expected=1110", count);
    end
    Ep = 1'b1; Ci = 'x;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (count !== exp_seq[i]) begin
        n_err++;
        $display("FAIL wrap[%0d]: count=%b expected=%b", i, count, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    Cp = 1'b1; Ep = 1'b0; Ci = 4'b0110;
    tick();
    rst = 1'b1; Ep = 1'b1; Ci = 4'b1011;
    tick();
    n_cmp++;
    if (count !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid: count=%b expected=0000", count);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (count !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_release: count=%b expected=0001", count);
    end
  endtask

  // Random controls against an arithmetic model of the PC rules.
  task automatic test_random();
    exp_pc = int'(count);
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 15) == 0);
      Cp  = 1'($urandom_range(0, 1));
      Ep  = 1'($urandom_range(0, 1));
      if (!rst && (!Cp || Ep) && ($urandom_range(0, 3) == 0)) begin
        Ci = 'x;
      end else begin
        Ci = W'($urandom_range(0, MODV - 1));
      end
      if (rst) begin
        exp_pc = 0;
      end else if (!Cp) begin
        exp_pc = exp_pc;
      end else if (Ep) begin
        exp_pc = (exp_pc + 1) % MODV;
      end else begin
        exp_pc = int'(Ci);
      end
      tick();
      n_cmp++;
      if (count !== W'(exp_pc)) begin
        n_err++;
        $display("FAIL random[%0d]: rst=%b Cp=%b Ep=%b Ci=%b count=%b expected=%b",
                 i, rst, Cp, Ep, Ci, count, W'(exp_pc));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; Cp = 1'b0; Ep = 1'b0; Ci = '0;
    #2;
    test_reset();
    test_hold();
    test_count();
    test_reset();
    test_load();
    test_wrap();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
